// File: rtl/toggle_strobe_gen.sv
// Programmable toggle-strobe generator feeding a downstream T flip-flop.
// Define TOGGLE_STROBE_BURST_EN to enable burst mode, the DONE state and the done pulse.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last toggles count
// RUN   | period counter active, strobe issued on each terminal count
// DONE  | burst complete; next edge pulses done and returns to IDLE
module toggle_strobe_gen #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   div,
  input  logic               burst,
  input  logic [BURST_W-1:0] burst_len,
  output logic               t,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] toggles
);

  typedef enum logic [1:0] {
    IDLE,
    RUN
`ifdef TOGGLE_STROBE_BURST_EN
    , DONE
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic               t_d;
  logic [BURST_W-1:0] tog_d;

`ifdef TOGGLE_STROBE_BURST_EN
  logic               burst_q, burst_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic               done_q, done_d;
`else
  logic               unused_cfg;
  assign unused_cfg = ^{burst, burst_len};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    t_d     = 1'b0;
    tog_d   = toggles;
`ifdef TOGGLE_STROBE_BURST_EN
    burst_d = burst_q;
    len_d   = len_q;
    done_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          div_d   = div;
          cnt_d   = div;
          tog_d   = '0;
`ifdef TOGGLE_STROBE_BURST_EN
          burst_d = burst;
          len_d   = burst_len;
`endif
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end
`ifdef TOGGLE_STROBE_BURST_EN
        // zero-length burst completes without ever strobing
        else if (burst_q && (len_q == '0)) begin
          state_d = DONE;
        end
`endif
        else if (cnt_q == '0) begin
          t_d   = 1'b1;
          cnt_d = div_q;
          tog_d = toggles + 1'b1;
`ifdef TOGGLE_STROBE_BURST_EN
          if (burst_q && (tog_d == len_q)) state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef TOGGLE_STROBE_BURST_EN
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      div_q   <= '0;
      t       <= 1'b0;
      toggles <= '0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      t       <= t_d;
      toggles <= tog_d;
    end
  end

`ifdef TOGGLE_STROBE_BURST_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_q <= 1'b0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      burst_q <= burst_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
`else
  assign done = 1'b0;
`endif

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_toggle_strobe_gen.sv
// Bench for toggle_strobe_gen: arithmetic reference model compared every cycle,
// plus directed literal checks. Burst checks follow TOGGLE_STROBE_BURST_EN.
module tb_toggle_strobe_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       burst = 1'b0;
  logic [7:0] div = 8'd0;
  logic [3:0] burst_len = 4'd0;
  logic       t, busy, done;
  logic [3:0] toggles;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  toggle_strobe_gen #(.CNT_W(8), .BURST_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .div(div),
    .burst(burst), .burst_len(burst_len), .t(t), .busy(busy),
    .done(done), .toggles(toggles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: k counts edges since the accepted start; strobes land on
  // every multiple of (div+1); a burst ends on the edge after its last strobe.
  bit         m_run;
  int         k, md, mlen;
  bit         mbm;
  logic       m_t, m_busy, m_done;
  logic [3:0] m_tog;

  function automatic int end_edge(input bit bm, input int len, input int d);
    if (!bm) return -1;
    if (len == 0) return 2;
    return len * (d + 1) + 1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; k = 0; m_t = 0; m_busy = 0; m_done = 0; m_tog = 0;
    end else if (!m_run) begin
      m_t = 0; m_done = 0; m_busy = 0;
      if (start && !stop) begin
        m_run = 1; k = 0; md = int'(div); mlen = int'(burst_len); m_tog = 0; m_busy = 1;
`ifdef TOGGLE_STROBE_BURST_EN
        mbm = burst;
`else
        mbm = 0;
`endif
      end
    end else begin
      k++;
      if (k == end_edge(mbm, mlen, md)) begin
        m_done = 1; m_t = 0; m_busy = 0; m_run = 0;
      end else if (stop) begin
        m_t = 0; m_busy = 0; m_run = 0;
      end else begin
        m_t = !(mbm && mlen == 0) && (k % (md + 1) == 0);
        if (m_t) m_tog = m_tog + 4'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_t", t, m_t);
      chk("model_busy", busy, m_busy);
      chk("model_done", done, m_done);
      chk("model_toggles", toggles, m_tog);
    end
  end

  task automatic after(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] d, input logic b, input logic [3:0] len);
    div = d; burst = b; burst_len = len; start = 1'b1;
    after(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    after(1);
    stop = 1'b0;
  endtask

  initial begin
    // reset held with start asserted
    rst = 1'b0; start = 1'b1; div = 8'd3;
    after(3);
    chk("rst_t", t, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_toggles", toggles, 0);
    start = 1'b0; rst = 1'b1; cmp_en = 1'b1;
    after(3);
    chk("idle_after_rst", busy, 0);

    // continuous, div=3
    go(8'd3, 1'b0, 4'd0);
    after(3);  chk("c3_e3_t", t, 0);
    after(1);  chk("c3_e4_t", t, 1);
    after(4);  chk("c3_e8_t", t, 1);
    after(4);  chk("c3_e12_t", t, 1); chk("c3_e12_tog", toggles, 3);
    after(1);
    pulse_stop();
    chk("c3_stop_busy", busy, 0); chk("c3_stop_tog", toggles, 3); chk("c3_stop_done", done, 0);
    after(1);

    // div=0: strobe every cycle
    go(8'd0, 1'b0, 4'd0);
    after(1);  chk("d0_e1_t", t, 1);
    after(4);  chk("d0_e5_t", t, 1); chk("d0_e5_tog", toggles, 5);
    pulse_stop();
    chk("d0_stop_busy", busy, 0);
    after(1);

    // start and stop together in IDLE
    div = 8'd5; start = 1'b1; stop = 1'b1;
    after(3);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0); chk("ss_t", t, 0); chk("ss_tog_kept", toggles, 5);
    after(1);

    // mid-run div change and start pulse are ignored; stop on a strobe edge
    go(8'd3, 1'b0, 4'd0);
    after(2);
    div = 8'd0; start = 1'b1;
    after(1);
    start = 1'b0;
    after(1);  chk("mr_e4_t", t, 1);
    after(1);  chk("mr_e5_t", t, 0);
    after(3);  chk("mr_e8_t", t, 1);
    after(3);
    pulse_stop();
    chk("mr_stop_t", t, 0); chk("mr_stop_busy", busy, 0); chk("mr_stop_tog", toggles, 2);
    after(1);

    // maximum divisor: period 256
    go(8'd255, 1'b0, 4'd0);
    after(255); chk("dmax_e255_t", t, 0);
    after(1);   chk("dmax_e256_t", t, 1);
    pulse_stop();
    after(1);

`ifdef TOGGLE_STROBE_BURST_EN
    go(8'd1, 1'b1, 4'd3);
    after(2);  chk("b3_e2_t", t, 1);
    after(2);  chk("b3_e4_t", t, 1);
    after(2);  chk("b3_e6_t", t, 1); chk("b3_e6_busy", busy, 1);
    after(1);  chk("b3_e7_done", done, 1); chk("b3_e7_busy", busy, 0);
               chk("b3_e7_tog", toggles, 3); chk("b3_e7_t", t, 0);
    after(1);  chk("b3_e8_done", done, 0);
    after(1);
    go(8'd0, 1'b1, 4'd0);
    after(1);  chk("b0_e1_t", t, 0); chk("b0_e1_busy", busy, 1);
    after(1);  chk("b0_e2_done", done, 1); chk("b0_e2_busy", busy, 0); chk("b0_e2_tog", toggles, 0);
    after(2);
`else
    go(8'd0, 1'b1, 4'd2);
    after(15); chk("nb_e15_tog", toggles, 15);
    after(1);  chk("nb_e16_tog", toggles, 0); chk("nb_e16_done", done, 0); chk("nb_e16_busy", busy, 1);
    pulse_stop();
    after(1);
`endif

    // asynchronous reset mid-run
    go(8'd2, 1'b0, 4'd0);
    after(4);  chk("ar_pre_tog", toggles, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_t", t, 0); chk("ar_busy", busy, 0); chk("ar_done", done, 0); chk("ar_tog", toggles, 0);
    after(2);
    rst = 1'b1;
    after(3);  chk("ar_idle", busy, 0);
    after(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
